// File: rtl/prime_checker.sv
// prime_checker: sequential primality tester for unsigned WIDTH-bit operands.
// The operand is trial-divided by 2, then by odd divisors d while d*d <= n. Each
// remainder comes from a restoring shift-subtract unit that handles one operand
// bit per cycle. A one-cycle valid_o pulse reports the result.
// Optional feature macro: PRIME_FACTOR_EN adds the factor_o port (smallest factor).
module prime_checker #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
`ifdef PRIME_FACTOR_EN
    output logic             prime_o,
    output logic [WIDTH-1:0] factor_o
`else
    output logic             prime_o
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StDivide,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, valid_q, prime_q;
    logic             res_prime;
`ifdef PRIME_FACTOR_EN
    logic [WIDTH-1:0] factor_q;
    logic [WIDTH-1:0] res_factor;
`endif

    // Square of the divisor at double width so it cannot overflow.
    logic [2*WIDTH-1:0] d_ext, n_ext, d_sq;
    assign d_ext = {{WIDTH{1'b0}}, d_q};
    assign n_ext = {{WIDTH{1'b0}}, n_q};
    assign d_sq  = d_ext * d_ext;

    // One restoring division step: shift in the next operand bit, subtract if it fits.
    logic [WIDTH:0] rem_shift, rem_sub, rem_next;
    assign rem_shift = {rem_q[WIDTH-1:0], shift_q[WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, d_q};
    assign rem_next  = (rem_shift >= {1'b0, d_q}) ? rem_sub : rem_shift;

    // Next-state logic, datapath updates and the result to latch on entry to DONE.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        d_d       = d_q;
        rem_d     = rem_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        res_prime = 1'b0;
`ifdef PRIME_FACTOR_EN
        res_factor = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    n_d = data_i;
                    d_d = WIDTH'(2);
                    if (data_i < WIDTH'(2)) begin
                        state_d = StDone;
                    end else if (data_i < WIDTH'(4)) begin
                        state_d   = StDone;
                        res_prime = 1'b1;
`ifdef PRIME_FACTOR_EN
                        res_factor = data_i;
`endif
                    end else begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (d_sq > n_ext) begin
                    state_d   = StDone;
                    res_prime = 1'b1;
`ifdef PRIME_FACTOR_EN
                    res_factor = n_q;
`endif
                end else begin
                    rem_d   = '0;
                    shift_d = n_q;
                    cnt_d   = CW'(WIDTH);
                    state_d = StDivide;
                end
            end
            StDivide: begin
                rem_d   = rem_next;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (rem_next == '0) begin
                        state_d = StDone;
`ifdef PRIME_FACTOR_EN
                        res_factor = d_q;
`endif
                    end else begin
                        d_d     = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
                        state_d = StCheck;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            d_q     <= WIDTH'(2);
            rem_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            prime_q <= 1'b0;
`ifdef PRIME_FACTOR_EN
            factor_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == StIdle);
            valid_q <= (state_d == StDone);
            if (state_d == StDone) begin
                prime_q <= res_prime;
`ifdef PRIME_FACTOR_EN
                factor_q <= res_factor;
`endif
            end
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign prime_o = prime_q;
`ifdef PRIME_FACTOR_EN
    assign factor_o = factor_q;
`endif

endmodule

// File: tb/tb_prime_checker.sv
// Directed bench for prime_checker (WIDTH = 8): small operands, latency cases,
// busy-request rejection, mid-operation reset and a full back-to-back sweep.
module tb_prime_checker;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic [WIDTH-1:0] data_i;
    logic             ready_o;
    logic             valid_o;
    logic             prime_o;
`ifdef PRIME_FACTOR_EN
    logic [WIDTH-1:0] factor_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    prime_checker #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
`ifdef PRIME_FACTOR_EN
        .prime_o (prime_o),
        .factor_o(factor_o)
`else
        .prime_o (prime_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model using plain arithmetic: primality, smallest factor, latency.
    task automatic model(input int n, output int is_p, output int fac, output int lat);
        int d;
        int k;
        if (n < 2) begin
            is_p = 0; fac = 0; lat = 1;
        end else if (n < 4) begin
            is_p = 1; fac = n; lat = 1;
        end else begin
            d = 2; k = 0; is_p = 1; fac = n;
            while (d * d <= n) begin
                k++;
                if (n % d == 0) begin
                    is_p = 0; fac = d;
                    break;
                end
                d = (d == 2) ? 3 : d + 2;
            end
            lat = is_p ? k * (WIDTH + 1) + 2 : k * (WIDTH + 1) + 1;
        end
    endtask

    // Accept one operand, measure latency, check outputs and the single-cycle strobe.
    task automatic run_op(input int n, input int exp_p, input int exp_f, input int exp_l,
                          input string tag);
        int cnt;
        chk({tag, " ready_before"}, int'(ready_o), 1);
        en_i   = 1'b1;
        data_i = WIDTH'(n);
        @(posedge clk);
        #1;
        en_i = 1'b0;
        cnt  = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!valid_o && cnt < 200);
        chk({tag, " latency"}, cnt, exp_l);
        chk({tag, " prime"}, int'(prime_o), exp_p);
`ifdef PRIME_FACTOR_EN
        chk({tag, " factor"}, int'(factor_o), exp_f);
`else
        if (exp_f < 0) $display("unexpected factor argument");
`endif
        @(negedge clk);
        chk({tag, " valid_one_cycle"}, int'(valid_o), 0);
    endtask

    int is_p, fac, lat, cnt, vcnt, first;

    initial begin
        rst    = 1'b1;
        en_i   = 1'b0;
        data_i = '0;
        repeat (2) @(negedge clk);
        chk("reset ready", int'(ready_o), 1);
        chk("reset valid", int'(valid_o), 0);
        chk("reset prime", int'(prime_o), 0);
`ifdef PRIME_FACTOR_EN
        chk("reset factor", int'(factor_o), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Small operands and hand-computed latencies.
        run_op(0, 0, 0, 1, "n0");
        run_op(1, 0, 0, 1, "n1");
        run_op(2, 1, 2, 1, "n2");
        run_op(3, 1, 3, 1, "n3");
        run_op(7, 1, 7, 11, "n7");
        run_op(9, 0, 3, 19, "n9");
        run_op(251, 1, 251, 74, "n251");
        run_op(255, 0, 3, 19, "n255");

        // Request while busy must be ignored.
        en_i   = 1'b1;
        data_i = WIDTH'(251);
        @(posedge clk);
        #1;
        en_i  = 1'b0;
        cnt   = 0;
        vcnt  = 0;
        first = 0;
        while (cnt < 90) begin
            @(negedge clk);
            cnt++;
            if (cnt == 5) begin
                en_i   = 1'b1;
                data_i = WIDTH'(4);
            end else if (cnt == 6) begin
                en_i = 1'b0;
            end
            if (valid_o) begin
                vcnt++;
                if (first == 0) begin
                    first = cnt;
                    chk("busy prime", int'(prime_o), 1);
                end
            end
        end
        chk("busy valid_count", vcnt, 1);
        chk("busy latency", first, 74);
        chk("busy ready_after", int'(ready_o), 1);

        // Reset during DIVIDE aborts the operation without a strobe.
        en_i   = 1'b1;
        data_i = WIDTH'(251);
        @(posedge clk);
        #1;
        en_i = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort valid_in_reset", int'(valid_o), 0);
        chk("abort ready_in_reset", int'(ready_o), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort ready_after", int'(ready_o), 1);
        vcnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid_o) vcnt++;
        end
        chk("abort no_valid", vcnt, 0);
        run_op(5, 1, 5, 11, "n5_after_reset");

        // Back-to-back sweep against the model.
        for (int n = 0; n < 256; n++) begin
            model(n, is_p, fac, lat);
            run_op(n, is_p, fac, lat, $sformatf("sweep%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
